// File: rtl/mod_arith_pkg.sv
// Shared constants for the modular arithmetic datapath.
// Opcodes, default geometry and the lattice moduli used by keygen.
package mod_arith_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int DEF_WIDTH = 24;
    localparam int DEF_LANES = 4;

    localparam logic [23:0] Q_DILITHIUM = 24'd8380417;
    localparam logic [23:0] Q_KYBER     = 24'd3329;

endpackage

// File: rtl/mod_addsub_lane.sv
// One lane of the modular add/sub: raw compute and final correction.
// Purely combinational; the pipeline registers live in the top.
module mod_addsub_lane
    import mod_arith_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
)
(
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] q,
    output logic [WIDTH:0]   raw,
    input  logic             s1_op,
    input  logic [WIDTH:0]   s1_raw,
    output logic [WIDTH-1:0] res
);

    logic [WIDTH:0] a_ext;
    logic [WIDTH:0] b_ext;
    logic [WIDTH:0] q_ext;

    assign a_ext = {1'b0, a};
    assign b_ext = {1'b0, b};
    assign q_ext = {1'b0, q};

    // Raw sum/difference; top bit is the carry (add) or borrow (sub).
    always_comb begin
        if (op == OP_SUB) begin
            raw = a_ext - b_ext;
        end else begin
            raw = a_ext + b_ext;
        end
    end

    // Single conditional correction back into [0, q).
    always_comb begin
        res = s1_raw[WIDTH-1:0];
        if (s1_op == OP_SUB) begin
            if (s1_raw[WIDTH]) begin
                res = WIDTH'(s1_raw + q_ext);
            end
        end else if (s1_raw >= q_ext) begin
            res = WIDTH'(s1_raw - q_ext);
        end
    end

endmodule

// File: rtl/mod_addsub_pipe.sv
// Two-stage multi-lane modular adder/subtractor with valid/ready.
// Optional operand range flag under MOD_ADDSUB_RANGE_CHK_EN.
module mod_addsub_pipe
    import mod_arith_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LANES = DEF_LANES
)
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       q,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_op,
    input  logic [LANES*WIDTH-1:0] in_a,
    input  logic [LANES*WIDTH-1:0] in_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_res,
    output logic                   out_err
);

    localparam int RW = WIDTH + 1;

    logic                   s1_valid;
    logic                   s1_op;
    logic [LANES*RW-1:0]    s1_raw;
    logic [LANES*RW-1:0]    raw_next;
    logic [LANES*WIDTH-1:0] res_next;
    logic                   s1_advance;

    assign s1_advance = !out_valid || out_ready;
    assign in_ready   = !s1_valid || s1_advance;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        mod_addsub_lane #(.WIDTH(WIDTH)) u_lane (
            .op     (in_op),
            .a      (in_a[i*WIDTH +: WIDTH]),
            .b      (in_b[i*WIDTH +: WIDTH]),
            .q      (q),
            .raw    (raw_next[i*RW +: RW]),
            .s1_op  (s1_op),
            .s1_raw (s1_raw[i*RW +: RW]),
            .res    (res_next[i*WIDTH +: WIDTH])
        );
    end

    // S1: capture raw results whenever the stage can take new data.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_op    <= OP_ADD;
            s1_raw   <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_op  <= in_op;
                s1_raw <= raw_next;
            end
        end
    end

    // S2: corrected result register, held while downstream stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_res   <= '0;
        end else if (s1_advance) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_res <= res_next;
            end
        end
    end

`ifdef MOD_ADDSUB_RANGE_CHK_EN
    logic range_next;
    logic s1_err;
    logic err_q;

    // Flag any lane whose operand is not reduced modulo q.
    always_comb begin
        range_next = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (in_a[i*WIDTH +: WIDTH] >= q ||
                in_b[i*WIDTH +: WIDTH] >= q) begin
                range_next = 1'b1;
            end
        end
    end

    // Range flag travels with its transaction through both stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_err <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            if (in_ready && in_valid) begin
                s1_err <= range_next;
            end
            if (s1_advance && s1_valid) begin
                err_q <= s1_err;
            end
        end
    end

    assign out_err = err_q;
`else
    assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_mod_addsub_pipe.sv
// Self-checking bench for mod_addsub_pipe (WIDTH=24, LANES=4).
// Directed vector table plus stall, streaming and reset sequences.
module tb_mod_addsub_pipe;

    localparam int W = 24;
    localparam int L = 4;
    localparam logic [23:0] QD = 24'd8380417;
    localparam logic [23:0] QK = 24'd3329;
`ifdef MOD_ADDSUB_RANGE_CHK_EN
    localparam logic RC = 1'b1;
`else
    localparam logic RC = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic [W-1:0]   q;
    logic           in_valid;
    logic           in_ready;
    logic           in_op;
    logic [L*W-1:0] in_a;
    logic [L*W-1:0] in_b;
    logic           out_valid;
    logic           out_ready;
    logic [L*W-1:0] out_res;
    logic           out_err;

    int n_checks = 0;
    int n_fail   = 0;

    mod_addsub_pipe #(.WIDTH(W), .LANES(L)) dut (
        .clk       (clk),
        .rst       (rst),
        .q         (q),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic           op;
        logic [W-1:0]   q;
        logic [L*W-1:0] a;
        logic [L*W-1:0] b;
        logic [L*W-1:0] res;
        logic           err;
    } vec_t;

    vec_t vecs[8];

    function automatic logic [L*W-1:0] pack4(
        input logic [W-1:0] x0, input logic [W-1:0] x1,
        input logic [W-1:0] x2, input logic [W-1:0] x3);
        return {x3, x2, x1, x0};
    endfunction

    function automatic logic [W-1:0] model(
        input logic op, input logic [W-1:0] a,
        input logic [W-1:0] b, input logic [W-1:0] m);
        longint r;
        if (op) r = (longint'(a) - longint'(b) + longint'(m)) % longint'(m);
        else    r = (longint'(a) + longint'(b)) % longint'(m);
        return W'(r);
    endfunction

    task automatic check(input string name,
                         input logic [L*W-1:0] act,
                         input logic [L*W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int k);
        @(posedge clk); #1;
        q         = vecs[k].q;
        in_valid  = 1'b1;
        in_op     = vecs[k].op;
        in_a      = vecs[k].a;
        in_b      = vecs[k].b;
        out_ready = 1'b1;
        @(negedge clk);
        check($sformatf("vec%0d in_ready", k), 96'(in_ready), 96'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check($sformatf("vec%0d early_valid", k), 96'(out_valid), 96'(0));
        @(negedge clk);
        check($sformatf("vec%0d out_valid", k), 96'(out_valid), 96'(1));
        check($sformatf("vec%0d out_res", k), out_res, vecs[k].res);
        check($sformatf("vec%0d out_err", k), 96'(out_err), 96'(vecs[k].err));
    endtask

    logic [L*W-1:0] sa[16];
    logic [L*W-1:0] sb[16];
    logic [L*W-1:0] se[16];
    logic           sop[16];
    logic [L*W-1:0] t0_res;
    logic [L*W-1:0] t1_res;
    logic [L*W-1:0] held;
    logic           stall_pend;
    int sent;
    int got;
    int cyc;

    initial begin
        vecs[0] = '{1'b0, QD,
            pack4(24'd8380416, 24'd4190208, 24'd100, 24'd8380416),
            pack4(24'd1, 24'd4190208, 24'd200, 24'd8380416),
            pack4(24'd0, 24'd8380416, 24'd300, 24'd8380415), 1'b0};
        vecs[1] = '{1'b1, QD,
            pack4(24'd0, 24'd5, 24'd8380416, 24'd1000),
            pack4(24'd1, 24'd3, 24'd8380416, 24'd8380416),
            pack4(24'd8380416, 24'd2, 24'd0, 24'd1001), 1'b0};
        vecs[2] = '{1'b0, QK,
            pack4(24'd3328, 24'd1, 24'd3328, 24'd0),
            pack4(24'd3328, 24'd2, 24'd1, 24'd0),
            pack4(24'd3327, 24'd3, 24'd0, 24'd0), 1'b0};
        vecs[3] = '{1'b1, QK,
            pack4(24'd0, 24'd3328, 24'd17, 24'd2000),
            pack4(24'd3328, 24'd0, 24'd20, 24'd1000),
            pack4(24'd1, 24'd3328, 24'd3326, 24'd1000), 1'b0};
        vecs[4] = '{1'b0, QK,
            pack4(24'd3329, 24'd0, 24'd0, 24'd0),
            pack4(24'd0, 24'd0, 24'd0, 24'd0),
            pack4(24'd0, 24'd0, 24'd0, 24'd0), RC};
        vecs[5] = '{1'b0, QK,
            pack4(24'd3328, 24'd0, 24'd0, 24'd0),
            pack4(24'd0, 24'd0, 24'd0, 24'd0),
            pack4(24'd3328, 24'd0, 24'd0, 24'd0), 1'b0};
        vecs[6] = '{1'b0, 24'd2,
            pack4(24'd1, 24'd1, 24'd0, 24'd0),
            pack4(24'd1, 24'd0, 24'd1, 24'd0),
            pack4(24'd0, 24'd1, 24'd1, 24'd0), 1'b0};
        vecs[7] = '{1'b0, 24'd16777215,
            pack4(24'd16777214, 24'd16777214, 24'd0, 24'd16777213),
            pack4(24'd16777214, 24'd1, 24'd0, 24'd1),
            pack4(24'd16777213, 24'd0, 24'd0, 24'd16777214), 1'b0};

        rst       = 1'b1;
        q         = QD;
        in_valid  = 1'b0;
        in_op     = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst out_valid", 96'(out_valid), 96'(0));
        check("rst out_res", out_res, 96'(0));
        check("rst out_err", 96'(out_err), 96'(0));
        check("rst in_ready", 96'(in_ready), 96'(1));

        for (int k = 0; k < 8; k++) run_vec(k);

        // Fill the pipe with downstream stalled, then drain.
        t0_res = pack4(24'd11, 24'd22, 24'd33, 24'd44);
        t1_res = pack4(24'd8380408, 24'd8380399, 24'd8380390, 24'd8380381);
        @(posedge clk); #1;
        q = QD; out_ready = 1'b0; in_valid = 1'b1; in_op = 1'b0;
        in_a = pack4(24'd10, 24'd20, 24'd30, 24'd40);
        in_b = pack4(24'd1, 24'd2, 24'd3, 24'd4);
        @(negedge clk);
        check("fill rdy0", 96'(in_ready), 96'(1));
        @(posedge clk); #1;
        in_op = 1'b1;
        in_a = pack4(24'd1, 24'd2, 24'd3, 24'd4);
        in_b = pack4(24'd10, 24'd20, 24'd30, 24'd40);
        @(negedge clk);
        check("fill rdy1", 96'(in_ready), 96'(1));
        @(posedge clk); #1;
        in_op = 1'b0;
        in_a = pack4(24'd7, 24'd7, 24'd7, 24'd7);
        in_b = pack4(24'd7, 24'd7, 24'd7, 24'd7);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("stall%0d in_ready", c), 96'(in_ready), 96'(0));
            check($sformatf("stall%0d valid", c), 96'(out_valid), 96'(1));
            check($sformatf("stall%0d res", c), out_res, t0_res);
        end
        @(posedge clk); #1;
        out_ready = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        check("drain0 valid", 96'(out_valid), 96'(1));
        check("drain0 res", out_res, t0_res);
        check("drain0 in_ready", 96'(in_ready), 96'(1));
        @(negedge clk);
        check("drain1 valid", 96'(out_valid), 96'(1));
        check("drain1 res", out_res, t1_res);
        @(negedge clk);
        check("drain2 valid", 96'(out_valid), 96'(0));

        // Streaming with random backpressure and alternating op.
        for (int i = 0; i < 16; i++) begin
            logic [W-1:0] x [L];
            logic [W-1:0] y [L];
            sop[i] = 1'(i % 2);
            for (int l = 0; l < L; l++) begin
                x[l] = W'($urandom_range(int'(QD) - 1));
                y[l] = W'($urandom_range(int'(QD) - 1));
            end
            sa[i] = pack4(x[0], x[1], x[2], x[3]);
            sb[i] = pack4(y[0], y[1], y[2], y[3]);
            se[i] = pack4(model(sop[i], x[0], y[0], QD),
                          model(sop[i], x[1], y[1], QD),
                          model(sop[i], x[2], y[2], QD),
                          model(sop[i], x[3], y[3], QD));
        end
        sent = 0; got = 0; cyc = 0; stall_pend = 1'b0; held = '0;
        while (got < 16 && cyc < 1000) begin
            @(posedge clk); #1;
            out_ready = 1'($urandom_range(1, 0));
            if (sent < 16) begin
                in_valid = 1'b1;
                in_op    = sop[sent];
                in_a     = sa[sent];
                in_b     = sb[sent];
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (stall_pend) begin
                check($sformatf("strm hold v%0d", got), 96'(out_valid), 96'(1));
                check($sformatf("strm hold r%0d", got), out_res, held);
            end
            if (out_valid && out_ready) begin
                check($sformatf("strm res%0d", got), out_res, se[got]);
                got++;
            end
            stall_pend = out_valid && !out_ready;
            held = out_res;
            if (in_valid && in_ready) sent++;
            cyc++;
        end
        check("strm count", 96'(got), 96'(16));
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("strm no dup", 96'(out_valid), 96'(0));

        // Reset with two transactions in flight.
        @(posedge clk); #1;
        q = QD; in_valid = 1'b1; in_op = 1'b0;
        in_a = pack4(24'd1, 24'd1, 24'd1, 24'd1);
        in_b = pack4(24'd1, 24'd1, 24'd1, 24'd1);
        @(posedge clk); #1;
        in_op = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mrst out_valid", 96'(out_valid), 96'(0));
        check("mrst out_res", out_res, 96'(0));
        check("mrst in_ready", 96'(in_ready), 96'(1));
        @(negedge clk);
        check("mrst no ghost", 96'(out_valid), 96'(0));
        run_vec(1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
